// File: rtl/audio_echo_pkg.sv
`default_nettype none
// ---------------------------------------------------------------------------
// audio_echo_pkg : shared widths, saturation limits and FSM encoding
// Rev 1.0
// ---------------------------------------------------------------------------
package audio_echo_pkg;

  localparam int DEF_SAMPLE_W = 24;
  localparam int DEF_ADDR_W   = 12;
  localparam int DEF_GAIN_W   = 8;

  localparam logic [DEF_SAMPLE_W-1:0] SAT_MAX = {1'b0, {(DEF_SAMPLE_W-1){1'b1}}};
  localparam logic [DEF_SAMPLE_W-1:0] SAT_MIN = {1'b1, {(DEF_SAMPLE_W-1){1'b0}}};

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RD   = 2'd1,
    ST_MUL  = 2'd2,
    ST_SUM  = 2'd3
  } state_t;

endpackage
`default_nettype wire

// File: rtl/echo_delay_ram.sv
`default_nettype none
// ---------------------------------------------------------------------------
// echo_delay_ram : single-port synchronous RAM, one-cycle read, no reset
// Rev 1.0
// ---------------------------------------------------------------------------
module echo_delay_ram
  import audio_echo_pkg::*;
#(
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int DATA_W = 2 * DEF_SAMPLE_W
) (
  input  logic              clk,
  input  logic              en,
  input  logic              we,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] din,
  output logic [DATA_W-1:0] dout
);

  logic [DATA_W-1:0] mem [2**ADDR_W];
  logic [DATA_W-1:0] dout_q;

  always_ff @(posedge clk) begin
    if (en) begin
      if (we) begin
        mem[addr] <= din;
      end else begin
        dout_q <= mem[addr];
      end
    end
  end

  assign dout = dout_q;

endmodule
`default_nettype wire

// File: rtl/audio_echo.sv
`default_nettype none
// ---------------------------------------------------------------------------
// audio_echo : stereo echo, BRAM delay line, gain-scaled saturating mix
// Build option: ECHO_FEEDBACK_EN stores the wet output (multi-tap decay). Rev 1.0
// ---------------------------------------------------------------------------
module audio_echo
  import audio_echo_pkg::*;
#(
  parameter int SAMPLE_W = DEF_SAMPLE_W,
  parameter int ADDR_W   = DEF_ADDR_W,
  parameter int GAIN_W   = DEF_GAIN_W
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                new_frame,
  input  logic [SAMPLE_W-1:0] rec_left,
  input  logic [SAMPLE_W-1:0] rec_right,
  input  logic [ADDR_W-1:0]   delay_len,
  input  logic [GAIN_W-1:0]   gain,
  output logic [SAMPLE_W-1:0] play_left,
  output logic [SAMPLE_W-1:0] play_right,
  output logic                out_valid,
  output logic                overrun
);

  localparam int PROD_W = SAMPLE_W + GAIN_W + 1;
  localparam logic [SAMPLE_W-1:0] c_sat_max  = {1'b0, {(SAMPLE_W-1){1'b1}}};
  localparam logic [SAMPLE_W-1:0] c_sat_min  = {1'b1, {(SAMPLE_W-1){1'b0}}};
  localparam logic [ADDR_W-1:0]   c_fill_max = {ADDR_W{1'b1}};

  // Signed sample times zero-extended unsigned gain.
  function automatic logic signed [PROD_W-1:0] scale(input logic [SAMPLE_W-1:0] d,
                                                     input logic [GAIN_W-1:0]   g);
    logic signed [PROD_W-1:0] d_ext;
    logic signed [PROD_W-1:0] g_ext;
    d_ext = {{(GAIN_W+1){d[SAMPLE_W-1]}}, d};
    g_ext = {{(SAMPLE_W+1){1'b0}}, g};
    return d_ext * g_ext;
  endfunction

  function automatic logic [SAMPLE_W-1:0] mix_sat(input logic [SAMPLE_W-1:0]     dry,
                                                  input logic signed [PROD_W-1:0] prod);
    logic signed [PROD_W-1:0] scaled;
    logic [SAMPLE_W:0]        s;
    scaled = prod >>> GAIN_W;
    s = {dry[SAMPLE_W-1], dry} + scaled[SAMPLE_W:0];
    if (s[SAMPLE_W] != s[SAMPLE_W-1]) begin
      return s[SAMPLE_W] ? c_sat_min : c_sat_max;
    end
    return s[SAMPLE_W-1:0];
  endfunction

  state_t                   state_q, state_d;
  logic [SAMPLE_W-1:0]      in_l_q, in_l_d, in_r_q, in_r_d;
  logic [ADDR_W-1:0]        dly_q, dly_d;
  logic [GAIN_W-1:0]        gain_q, gain_d;
  logic [ADDR_W-1:0]        rd_addr_q, rd_addr_d;
  logic [ADDR_W-1:0]        wr_ptr_q, wr_ptr_d;
  logic [ADDR_W-1:0]        fill_q, fill_d;
  logic signed [PROD_W-1:0] pl_q, pl_d, pr_q, pr_d;
  logic [SAMPLE_W-1:0]      sum_l_q, sum_l_d, sum_r_q, sum_r_d;
  logic                     done_q, done_d;
  logic [SAMPLE_W-1:0]      play_left_q, play_left_d, play_right_q, play_right_d;
  logic                     out_valid_q, out_valid_d;
  logic                     overrun_q, overrun_d;

  logic                     ram_en, ram_we;
  logic [ADDR_W-1:0]        ram_addr;
  logic [2*SAMPLE_W-1:0]    ram_din, ram_dout;
  logic                     echo_mask;
  logic [SAMPLE_W-1:0]      delayed_l, delayed_r;
  logic [SAMPLE_W-1:0]      sat_l, sat_r;

  // Slots not yet written since reset hold stale data and must read as silence.
  assign echo_mask = (dly_q == '0) || (fill_q < dly_q);
  assign delayed_l = echo_mask ? '0 : ram_dout[2*SAMPLE_W-1:SAMPLE_W];
  assign delayed_r = echo_mask ? '0 : ram_dout[SAMPLE_W-1:0];
  assign sat_l     = mix_sat(in_l_q, pl_q);
  assign sat_r     = mix_sat(in_r_q, pr_q);

  assign ram_en   = (state_q == ST_RD) || (state_q == ST_SUM);
  assign ram_we   = (state_q == ST_SUM);
  assign ram_addr = ram_we ? wr_ptr_q : rd_addr_q;
`ifdef ECHO_FEEDBACK_EN
  assign ram_din  = {sat_l, sat_r};
`else
  assign ram_din  = {in_l_q, in_r_q};
`endif

  echo_delay_ram #(
    .ADDR_W (ADDR_W),
    .DATA_W (2 * SAMPLE_W)
  ) u_ram (
    .clk  (clk),
    .en   (ram_en),
    .we   (ram_we),
    .addr (ram_addr),
    .din  (ram_din),
    .dout (ram_dout)
  );

  always_comb begin
    state_d      = state_q;
    in_l_d       = in_l_q;
    in_r_d       = in_r_q;
    dly_d        = dly_q;
    gain_d       = gain_q;
    rd_addr_d    = rd_addr_q;
    wr_ptr_d     = wr_ptr_q;
    fill_d       = fill_q;
    pl_d         = pl_q;
    pr_d         = pr_q;
    sum_l_d      = sum_l_q;
    sum_r_d      = sum_r_q;
    done_d       = 1'b0;
    overrun_d    = overrun_q | (new_frame && (state_q != ST_IDLE));
    // Output stage publishes the mixed frame one cycle after SUM.
    play_left_d  = done_q ? sum_l_q : play_left_q;
    play_right_d = done_q ? sum_r_q : play_right_q;
    out_valid_d  = done_q;

    case (state_q)
      ST_IDLE: begin
        if (new_frame) begin
          in_l_d    = rec_left;
          in_r_d    = rec_right;
          dly_d     = delay_len;
          gain_d    = gain;
          rd_addr_d = wr_ptr_q - delay_len;
          state_d   = ST_RD;
        end
      end
      ST_RD: begin
        state_d = ST_MUL;
      end
      ST_MUL: begin
        pl_d    = scale(delayed_l, gain_q);
        pr_d    = scale(delayed_r, gain_q);
        state_d = ST_SUM;
      end
      ST_SUM: begin
        sum_l_d  = sat_l;
        sum_r_d  = sat_r;
        done_d   = 1'b1;
        wr_ptr_d = wr_ptr_q + ADDR_W'(1);
        fill_d   = (fill_q == c_fill_max) ? fill_q : fill_q + ADDR_W'(1);
        state_d  = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= ST_IDLE;
      in_l_q       <= '0;
      in_r_q       <= '0;
      dly_q        <= '0;
      gain_q       <= '0;
      rd_addr_q    <= '0;
      wr_ptr_q     <= '0;
      fill_q       <= '0;
      pl_q         <= '0;
      pr_q         <= '0;
      sum_l_q      <= '0;
      sum_r_q      <= '0;
      done_q       <= 1'b0;
      play_left_q  <= '0;
      play_right_q <= '0;
      out_valid_q  <= 1'b0;
      overrun_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      in_l_q       <= in_l_d;
      in_r_q       <= in_r_d;
      dly_q        <= dly_d;
      gain_q       <= gain_d;
      rd_addr_q    <= rd_addr_d;
      wr_ptr_q     <= wr_ptr_d;
      fill_q       <= fill_d;
      pl_q         <= pl_d;
      pr_q         <= pr_d;
      sum_l_q      <= sum_l_d;
      sum_r_q      <= sum_r_d;
      done_q       <= done_d;
      play_left_q  <= play_left_d;
      play_right_q <= play_right_d;
      out_valid_q  <= out_valid_d;
      overrun_q    <= overrun_d;
    end
  end

  assign play_left  = play_left_q;
  assign play_right = play_right_q;
  assign out_valid  = out_valid_q;
  assign overrun    = overrun_q;

endmodule
`default_nettype wire

// File: tb/tb_audio_echo.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tb_audio_echo : scoreboard bench for audio_echo (either ECHO_FEEDBACK_EN build)
// Rev 1.0
// ---------------------------------------------------------------------------
module tb_audio_echo;

  localparam int SW    = 24;
  localparam int AW    = 12;
  localparam int GW    = 8;
  localparam int DEPTH = 1 << AW;

  logic          clk = 1'b0;
  logic          reset;
  logic          new_frame;
  logic [SW-1:0] rec_left, rec_right;
  logic [AW-1:0] delay_len;
  logic [GW-1:0] gain;
  logic [SW-1:0] play_left, play_right;
  logic          out_valid, overrun;

  audio_echo dut (
    .clk        (clk),
    .reset      (reset),
    .new_frame  (new_frame),
    .rec_left   (rec_left),
    .rec_right  (rec_right),
    .delay_len  (delay_len),
    .gain       (gain),
    .play_left  (play_left),
    .play_right (play_right),
    .out_valid  (out_valid),
    .overrun    (overrun)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  task automatic check_val(input string tag, input logic [47:0] obs, input logic [47:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference model: delay line contents, write pointer and fill level.
  typedef struct {
    logic [SW-1:0] l;
    logic [SW-1:0] r;
  } exp_t;

  exp_t            sb[$];
  logic [2*SW-1:0] m_mem [DEPTH];
  int              m_wr;
  int              m_fill;

  function automatic logic [SW-1:0] m_mix(input logic [SW-1:0] x, input logic [SW-1:0] d,
                                          input int g);
    longint p, s;
    p = longint'($signed(d)) * longint'(g);
    s = longint'($signed(x)) + (p >>> GW);
    if (s > 64'sd8388607)  s = 64'sd8388607;
    if (s < -64'sd8388608) s = -64'sd8388608;
    return SW'(s);
  endfunction

  task automatic m_frame(input logic [SW-1:0] l, input logic [SW-1:0] r, input int dly,
                         input int g);
    logic [2*SW-1:0] d;
    exp_t            e;
    d = (dly == 0 || m_fill < dly) ? '0 : m_mem[(m_wr - dly) & (DEPTH - 1)];
    e.l = m_mix(l, d[2*SW-1:SW], g);
    e.r = m_mix(r, d[SW-1:0], g);
    sb.push_back(e);
`ifdef ECHO_FEEDBACK_EN
    m_mem[m_wr] = {e.l, e.r};
`else
    m_mem[m_wr] = {l, r};
`endif
    m_wr = (m_wr + 1) & (DEPTH - 1);
    if (m_fill < DEPTH - 1) m_fill++;
  endtask

  // Scoreboard monitor: every output pulse must match the oldest pending frame.
  always @(negedge clk) begin
    if (out_valid) begin
      if (sb.size() == 0) begin
        check_val("spurious_out_valid", 48'(out_valid), 48'd0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        check_val("play_left", 48'(play_left), 48'(e.l));
        check_val("play_right", 48'(play_right), 48'(e.r));
      end
    end
  end

  initial begin
    #1_500_000;
    $display("FAIL watchdog expired checks=%0d errors=%0d", n_checks, n_errors);
    $fatal(1);
  end

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    sb.delete();
    m_wr   = 0;
    m_fill = 0;
  endtask

  task automatic drive_frame(input logic [SW-1:0] l, input logic [SW-1:0] r, input int dly,
                             input int g);
    rec_left  = l;
    rec_right = r;
    delay_len = AW'(dly);
    gain      = GW'(g);
    new_frame = 1'b1;
  endtask

  task automatic send_frame(input logic [SW-1:0] l, input logic [SW-1:0] r, input int dly,
                            input int g, output logic [SW-1:0] ol, output logic [SW-1:0] orr);
    int lat;
    @(negedge clk);
    drive_frame(l, r, dly, g);
    m_frame(l, r, dly, g);
    @(negedge clk);
    new_frame = 1'b0;
    lat = -1;
    for (int k = 0; k <= 20; k++) begin
      if (out_valid) begin
        lat = k;
        break;
      end
      @(negedge clk);
    end
    check_val("latency", 48'(lat), 48'd4);
    ol  = play_left;
    orr = play_right;
    @(negedge clk);
    check_val("out_valid_width", 48'(out_valid), 48'd0);
  endtask

  task automatic wait_idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  logic [SW-1:0] ol, orr;
  logic [SW-1:0] outs [12];
  logic [SW-1:0] ins  [12];
  logic [SW-1:0] wrap_in [10];

  initial begin
    reset     = 1'b1;
    new_frame = 1'b0;
    rec_left  = '0;
    rec_right = '0;
    delay_len = '0;
    gain      = '0;
    m_wr      = 0;
    m_fill    = 0;
    wait_idle(3);
    check_val("rst_play_left", 48'(play_left), 48'd0);
    check_val("rst_play_right", 48'(play_right), 48'd0);
    check_val("rst_out_valid", 48'(out_valid), 48'd0);
    check_val("rst_overrun", 48'(overrun), 48'd0);
    reset = 1'b0;

    // Bypass
    send_frame(24'h100000, 24'hF00000, 0, 128, ol, orr);
    check_val("bypass_left", 48'(ol), 48'h100000);
    check_val("bypass_right", 48'(orr), 48'hF00000);
    check_val("bypass_overrun", 48'(overrun), 48'd0);

    // Impulse through a 3-frame delay at half gain
    do_reset();
    for (int i = 0; i < 12; i++) begin
      send_frame((i == 0) ? 24'h400000 : 24'h0, 24'h0, 3, 128, ol, orr);
      outs[i] = ol;
    end
    check_val("impulse_f0", 48'(outs[0]), 48'h400000);
    check_val("impulse_f1", 48'(outs[1]), 48'h0);
    check_val("impulse_f2", 48'(outs[2]), 48'h0);
    check_val("impulse_f3", 48'(outs[3]), 48'h200000);
    check_val("impulse_f4", 48'(outs[4]), 48'h0);
`ifdef ECHO_FEEDBACK_EN
    check_val("impulse_f6", 48'(outs[6]), 48'h100000);
    check_val("impulse_f9", 48'(outs[9]), 48'h080000);
`else
    check_val("impulse_f6", 48'(outs[6]), 48'h0);
    check_val("impulse_f9", 48'(outs[9]), 48'h0);
`endif

    // Saturation both directions
    do_reset();
    send_frame(24'h7FFFFF, 24'h0, 1, 255, ol, orr);
    send_frame(24'h7FFFFF, 24'h0, 1, 255, ol, orr);
    check_val("sat_max", 48'(ol), 48'h7FFFFF);
    do_reset();
    send_frame(24'h800000, 24'h0, 1, 255, ol, orr);
    send_frame(24'h800000, 24'h0, 1, 255, ol, orr);
    check_val("sat_min", 48'(ol), 48'h800000);

    // Fill masking: stale RAM from earlier tests must not leak through
    do_reset();
    for (int i = 0; i < 8; i++) begin
      ins[i] = SW'($urandom_range(1, 24'h3FFFFF));
      send_frame(ins[i], ~ins[i], 5, 255, ol, orr);
      outs[i] = ol;
    end
    for (int i = 0; i < 5; i++) begin
      check_val($sformatf("fill_dry_f%0d", i), 48'(outs[i]), 48'(ins[i]));
    end

    // Overrun: second strobe lands while busy
    @(negedge clk);
    drive_frame(24'h012345, 24'h054321, 0, 64);
    m_frame(24'h012345, 24'h054321, 0, 64);
    @(negedge clk);
    new_frame = 1'b0;
    @(negedge clk);
    drive_frame(24'h0ABCDE, 24'h0EDCBA, 0, 64);
    @(negedge clk);
    new_frame = 1'b0;
    wait_idle(12);
    check_val("overrun_set", 48'(overrun), 48'd1);
    check_val("overrun_sb_drained", 48'(sb.size()), 48'd0);
    send_frame(24'h000111, 24'h000222, 0, 64, ol, orr);
    check_val("overrun_sticky", 48'(overrun), 48'd1);
    do_reset();
    check_val("overrun_cleared", 48'(overrun), 48'd0);

    // Wrap: echo of frame k reappears at frame k+4095
    for (int i = 0; i < DEPTH + 10; i++) begin
      logic [SW-1:0] v;
      if (i < 10) begin
        v = SW'($urandom_range(1, 24'hFFFFFF));
        wrap_in[i] = v;
      end else if (i < DEPTH - 1) begin
        v = SW'($urandom());
      end else begin
        v = '0;
      end
      send_frame(v, 24'h0, DEPTH - 1, 128, ol, orr);
      if (i >= DEPTH - 1 && i < DEPTH - 1 + 10) begin
        logic [SW-1:0] e;
        e = SW'($signed(wrap_in[i - (DEPTH - 1)]) >>> 1);
        check_val($sformatf("wrap_echo_k%0d", i - (DEPTH - 1)), 48'(ol), 48'(e));
      end
    end

    // Reset while the frame sits in MUL: no pulse, outputs cleared
    @(negedge clk);
    drive_frame(24'h3AAAAA, 24'h155555, 0, 128);
    @(negedge clk);
    new_frame = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    sb.delete();
    m_wr   = 0;
    m_fill = 0;
    wait_idle(10);
    check_val("midrst_play_left", 48'(play_left), 48'd0);
    check_val("midrst_play_right", 48'(play_right), 48'd0);
    check_val("midrst_out_valid", 48'(out_valid), 48'd0);
    check_val("midrst_overrun", 48'(overrun), 48'd0);
    send_frame(24'h0C0FFE, 24'hF3F001, 2, 200, ol, orr);
    check_val("post_rst_dry_left", 48'(ol), 48'h0C0FFE);
    check_val("post_rst_dry_right", 48'(orr), 48'hF3F001);

    wait_idle(4);
    check_val("sb_empty", 48'(sb.size()), 48'd0);
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire
